// File: rtl/f_candidate_scheduler_pkg.sv
// Shared types and constants for the F-metric candidate scheduler.
// Field/counter width helpers, FSM states and the zero double used to clear the argmax.
package f_candidate_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [63:0] POS_ZERO = 64'h0;

    function automatic int awidth(input int a);
        return $clog2(a) + 1;
    endfunction

    function automatic int nwidth(input int j, input int a);
        return j * $clog2(a) + 1;
    endfunction

endpackage

// File: rtl/f_tag_fifo.sv
// Tag FIFO holding issued candidates until their in-order F results return.
// Latency: first-word fall-through, a pushed word is visible on rd_dat the next cycle.
// Backpressure: writes when full and reads when empty are dropped; the caller's credits prevent both.
module f_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign do_wr  = wr_vld && !full;
    assign do_rd  = rd_rdy && !empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/f_candidate_scheduler.sv
// Exhaustive A^J candidate sweep: loads H/y into the F-metric core, streams candidates, keeps the argmax F.
// Latency: first issue 2 cycles after start is sampled; done pulses 2 cycles after the final result.
// Backpressure: issues throttled by MAX_OUT credits and GAP spacing; core results are never stalled.
module f_candidate_scheduler
    import f_candidate_scheduler_pkg::*;
#(
    parameter int J       = 4,
    parameter int A       = 4,
    parameter int MAX_OUT = 8,
    parameter int GAP     = 4,
    localparam int AWIDTH = awidth(A),
    localparam int NWIDTH = nwidth(J, A),
    localparam int XW     = J * AWIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [J*64-1:0] H_in,
    input  logic [127:0]    y_in,
    output logic            busy,
    output logic            done,
    output logic [XW-1:0]   best_x,
    output logic [63:0]     best_F,
    output logic            err,
    output logic [J*64-1:0] core_H,
    output logic [127:0]    core_y,
    output logic            core_H_tvalid,
    output logic [XW-1:0]   core_x,
    output logic            core_x_tvalid,
    input  logic [63:0]     core_F,
    input  logic            core_F_tvalid
);
    localparam int N  = A ** J;
    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam int GW = $clog2(GAP) + 1;

    localparam logic [NWIDTH-1:0] N_L        = NWIDTH'(N);
    localparam logic [NWIDTH-1:0] LAST_L     = NWIDTH'(N - 1);
    localparam logic [OW-1:0]     MAX_OUT_L  = OW'(MAX_OUT);
    localparam logic [GW-1:0]     GAP_RELOAD = GW'(GAP - 1);
    localparam logic [AWIDTH-1:0] DIGIT_MAX  = AWIDTH'(A - 1);

    state_t            state;
    state_t            state_nxt;
    logic [XW-1:0]     x_cnt;
    logic [XW-1:0]     x_nxt;
    logic              carry;
    logic [NWIDTH-1:0] issued;
    logic [NWIDTH-1:0] received;
    logic [OW-1:0]     outstanding;
    logic [GW-1:0]     gap_cnt;
    logic              have_best;
    logic              start_acc;
    logic              issue;
    logic              res_ok;
    logic              res_err;
    logic [XW-1:0]     tag_x;
    logic              tag_empty;
    logic              tag_full;

    f_tag_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (XW)
    ) u_tag_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (issue),
        .wr_dat (x_cnt),
        .rd_rdy (res_ok),
        .rd_dat (tag_x),
        .empty  (tag_empty),
        .full   (tag_full)
    );

    // Mixed-radix increment: symbol 0 is the least significant digit, each digit wraps at A-1.
    always_comb begin
        x_nxt = x_cnt;
        carry = 1'b1;
        for (int j = 0; j < J; j++) begin
            if (carry) begin
                if (x_cnt[j*AWIDTH +: AWIDTH] == DIGIT_MAX) begin
                    x_nxt[j*AWIDTH +: AWIDTH] = '0;
                end else begin
                    x_nxt[j*AWIDTH +: AWIDTH] = x_cnt[j*AWIDTH +: AWIDTH] + AWIDTH'(1);
                    carry = 1'b0;
                end
            end
        end
    end

    // A result is only legitimate while something is outstanding; otherwise it is flagged.
    assign res_ok  = core_F_tvalid && (outstanding != '0) && !tag_empty;
    assign res_err = core_F_tvalid && (outstanding == '0);

    always_comb begin
        state_nxt     = state;
        start_acc     = 1'b0;
        issue         = 1'b0;
        busy          = (state != IDLE);
        done          = 1'b0;
        core_H_tvalid = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                core_H_tvalid = 1'b1;
                state_nxt     = ISSUE;
            end
            ISSUE: begin
                issue = (gap_cnt == '0) && (outstanding < MAX_OUT_L) &&
                        (issued < N_L) && !tag_full;
                if (issue && (issued == LAST_L)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (received == N_L) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign core_x_tvalid = issue;
    assign core_x        = x_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            x_cnt       <= '0;
            issued      <= '0;
            received    <= '0;
            outstanding <= '0;
            gap_cnt     <= '0;
            have_best   <= 1'b0;
            best_x      <= '0;
            best_F      <= POS_ZERO;
            err         <= 1'b0;
            core_H      <= '0;
            core_y      <= '0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                core_H      <= H_in;
                core_y      <= y_in;
                x_cnt       <= '0;
                issued      <= '0;
                received    <= '0;
                outstanding <= '0;
                gap_cnt     <= '0;
                have_best   <= 1'b0;
                best_x      <= '0;
                best_F      <= POS_ZERO;
                err         <= 1'b0;
            end else begin
                if (issue) begin
                    x_cnt   <= x_nxt;
                    issued  <= issued + NWIDTH'(1);
                    gap_cnt <= GAP_RELOAD;
                end else if (gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - GW'(1);
                end
                // Unsigned compare orders non-negative doubles correctly; ties keep the earlier tag.
                if (res_ok) begin
                    received  <= received + NWIDTH'(1);
                    have_best <= 1'b1;
                    if (!have_best || (core_F > best_F)) begin
                        best_x <= tag_x;
                        best_F <= core_F;
                    end
                end
                if (res_err) begin
                    err <= 1'b1;
                end
                case ({issue, res_ok})
                    2'b10:   outstanding <= outstanding + OW'(1);
                    2'b01:   outstanding <= outstanding - OW'(1);
                    default: outstanding <= outstanding;
                endcase
            end
        end
    end

endmodule
